// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int          CLKDIV_DIV_W       = 25;
    localparam int unsigned CLKDIV_DEFAULT_DIV = 24000000;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int clkdiv_ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor pair, clk_out and tick.
// With CLKDIV_PENDING_EN defined the pending flag is exported.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int          DIV_W       = CLKDIV_DIV_W,
    parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_data,
    output logic             clk_out,
    output logic             tick
`ifdef CLKDIV_PENDING_EN
   ,output logic             pending
`endif
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             running;
    logic             wrap;
    logic             apply_any;

    always_comb begin
        shadow_d  = wr_en ? wr_data : shadow_q;
        // A write landing on an apply cycle bypasses the shadow.
        apply_any = pending_q || wr_en;
        running   = en && (active_q != '0);
        wrap      = running && (cnt_q == active_q - DIV_W'(1));
        cnt_d     = cnt_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        active_d  = active_q;
        pending_d = pending_q || wr_en;
        if (restart || !running) begin
            cnt_d     = '0;
            clk_d     = 1'b0;
            active_d  = apply_any ? shadow_d : active_q;
            pending_d = 1'b0;
        end else if (wrap) begin
            cnt_d     = '0;
            clk_d     = !clk_q;
            tick_d    = !clk_q;
            active_d  = apply_any ? shadow_d : active_q;
            pending_d = 1'b0;
        end else begin
            cnt_d     = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            active_q  <= RST_DIV;
            shadow_q  <= RST_DIV;
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
`ifdef CLKDIV_PENDING_EN
    assign pending = pending_q;
`endif

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent glitch-free clock dividers with runtime divisors.
// CLKDIV_PENDING_EN adds the div_pending status output.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          DIV_W       = CLKDIV_DIV_W,
    parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic [NUM_CH-1:0]                ch_en,
    input  logic                             sync_restart,
    input  logic                             div_wr_en,
    input  logic [clkdiv_ch_w(NUM_CH)-1:0]   div_wr_ch,
    input  logic [DIV_W-1:0]                 div_wr_data,
    output logic [NUM_CH-1:0]                clk_out,
    output logic [NUM_CH-1:0]                tick
`ifdef CLKDIV_PENDING_EN
   ,output logic [NUM_CH-1:0]                div_pending
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no instance and are dropped.
        logic wr_hit;
        assign wr_hit = div_wr_en && (int'(div_wr_ch) == i);

        clkdiv_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (ch_en[i]),
            .restart (sync_restart),
            .wr_en   (wr_hit),
            .wr_data (div_wr_data),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
`ifdef CLKDIV_PENDING_EN
           ,.pending (div_pending[i])
`endif
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed + random bench for multi_clock_divider against a half-period model.
module tb_multi_clock_divider;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 25;
    localparam int CH_W        = 2;
    localparam int DEFAULT_DIV = 4;

    logic              clk_in = 1'b0;
    logic              reset  = 1'b1;
    logic [NUM_CH-1:0] ch_en  = '0;
    logic              sync_restart = 1'b0;
    logic              div_wr_en    = 1'b0;
    logic [CH_W-1:0]   div_wr_ch    = '0;
    logic [DIV_W-1:0]  div_wr_data  = '0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_PENDING_EN
    logic [NUM_CH-1:0] div_pending;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Model: cycles left in the current half-period, plus divisor bookkeeping.
    int m_left [NUM_CH];
    int m_act  [NUM_CH];
    int m_sh   [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_clk  [NUM_CH];
    bit m_tick [NUM_CH];

    multi_clock_divider #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .div_wr_en    (div_wr_en),
        .div_wr_ch    (div_wr_ch),
        .div_wr_data  (div_wr_data),
        .clk_out      (clk_out),
        .tick         (tick)
`ifdef CLKDIV_PENDING_EN
       ,.div_pending  (div_pending)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_act[i]  = DEFAULT_DIV;
            m_sh[i]   = DEFAULT_DIV;
            m_left[i] = DEFAULT_DIV;
            m_pend[i] = 1'b0;
            m_clk[i]  = 1'b0;
            m_tick[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            bit wr;
            int nsh;
            bit npend;
            wr    = div_wr_en && (int'(div_wr_ch) == i);
            nsh   = wr ? int'(div_wr_data) : m_sh[i];
            npend = m_pend[i] || wr;
            m_tick[i] = 1'b0;
            if (sync_restart || !ch_en[i] || m_act[i] == 0) begin
                m_act[i]  = nsh;
                m_left[i] = nsh;
                m_clk[i]  = 1'b0;
                npend     = 1'b0;
            end else if (m_left[i] == 1) begin
                m_clk[i]  = !m_clk[i];
                m_tick[i] = m_clk[i];
                m_act[i]  = nsh;
                m_left[i] = nsh;
                npend     = 1'b0;
            end else begin
                m_left[i] = m_left[i] - 1;
            end
            m_sh[i]   = nsh;
            m_pend[i] = npend;
        end
    endtask

    task automatic check();
        logic [NUM_CH-1:0] ec, et, ep;
        for (int i = 0; i < NUM_CH; i++) begin
            ec[i] = m_clk[i];
            et[i] = m_tick[i];
            ep[i] = m_pend[i];
        end
        vectors++;
        assert (clk_out === ec && tick === et) else begin
            miscompares++;
            $error("FAIL cycle t=%0t clk_out=%b want %b tick=%b want %b", $time, clk_out, ec, tick, et);
        end
`ifdef CLKDIV_PENDING_EN
        vectors++;
        assert (div_pending === ep) else begin
            miscompares++;
            $error("FAIL pending t=%0t div_pending=%b want %b", $time, div_pending, ep);
        end
`else
        if (ep != ep) $display("unreachable");
`endif
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        check();
    endtask

    task automatic wr(input int ch, input int val);
        div_wr_en   = 1'b1;
        div_wr_ch   = CH_W'(ch);
        div_wr_data = DIV_W'(val);
    endtask

    // Counts edges until clk_out[ch] changes; bounded so a stuck output fails.
    task automatic toggle_after(input int ch, input int exp, input string tag);
        logic v0;
        int   n;
        v0 = clk_out[ch];
        n  = 0;
        do begin
            cyc();
            n++;
        end while (clk_out[ch] === v0 && n < 40);
        vectors++;
        assert (n == exp) else begin
            miscompares++;
            $error("FAIL %s: clk_out[%0d] toggled after %0d cycles, want %0d", tag, ch, n, exp);
        end
    endtask

    initial begin
        int n;
        int ticks;
        logic [12:0] r0, r1;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk_in);
        check();
        reset = 1'b0;

        // ch0 at N=3
        wr(0, 3);
        cyc();
        div_wr_en = 1'b0;
        ch_en = 3'b001;
        toggle_after(0, 3, "first_rise_n3");
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (tick[0]) ticks++;
        end
        vectors++;
        assert (ticks == 2) else begin
            miscompares++;
            $error("FAIL tick_count_n3: %0d ticks in 12 cycles, want 2", ticks);
        end

        // Reprogram to 5 mid half-period
        cyc();
        wr(0, 5);
        cyc();
        div_wr_en = 1'b0;
        toggle_after(0, 1, "old_half_period");
        toggle_after(0, 5, "new_half_period_a");
        toggle_after(0, 5, "new_half_period_b");

        // Stop with N=0, then restart with N=2
        wr(0, 0);
        cyc();
        div_wr_en = 1'b0;
        repeat (10) cyc();
        vectors++;
        assert (clk_out[0] === 1'b0) else begin
            miscompares++;
            $error("FAIL stopped_low: clk_out[0]=%b want 0", clk_out[0]);
        end
        wr(0, 2);
        cyc();
        div_wr_en = 1'b0;
        toggle_after(0, 2, "restart_n2");

        // Phase alignment via sync_restart (ch1 at default 4)
        ch_en = 3'b011;
        repeat (5) cyc();
        sync_restart = 1'b1;
        cyc();
        sync_restart = 1'b0;
        vectors++;
        assert (clk_out[1:0] === 2'b00) else begin
            miscompares++;
            $error("FAIL restart_low: clk_out[1:0]=%b want 00", clk_out[1:0]);
        end
        r0 = '0;
        r1 = '0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            r0[k] = tick[0];
            r1[k] = tick[1];
        end
        vectors++;
        assert (r0 === 13'h0444 && r1 === 13'h1010) else begin
            miscompares++;
            $error("FAIL align: ch0 rises %h want 0444, ch1 rises %h want 1010", r0, r1);
        end

        // Write exactly on ch0's wrap, then an out-of-range write
        n = 0;
        while (m_left[0] != 1 && n < 10) begin
            cyc();
            n++;
        end
        wr(0, 7);
        cyc();
        wr(3, 1);
        cyc();
        div_wr_en = 1'b0;
        toggle_after(0, 6, "wrap_bypass_n7");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) ch_en = NUM_CH'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
            else div_wr_en = 1'b0;
            sync_restart = ($urandom_range(0, 29) == 0);
            cyc();
        end
        div_wr_en    = 1'b0;
        sync_restart = 1'b0;

        // Asynchronous reset while clk_out[0] is high
        ch_en = 3'b001;
        wr(0, 3);
        cyc();
        div_wr_en = 1'b0;
        n = 0;
        while (clk_out[0] !== 1'b1 && n < 30) begin
            cyc();
            n++;
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        assert (clk_out === '0 && tick === '0) else begin
            miscompares++;
            $error("FAIL async_reset: clk_out=%b tick=%b want 0/0 (clk_out[0] high first: %0d)", clk_out, tick, n < 30);
        end
        model_reset();
        ch_en = '0;
        @(negedge clk_in);
        check();
        reset = 1'b0;
        cyc();
        ch_en = 3'b001;
        toggle_after(0, DEFAULT_DIV, "post_reset_default");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
